// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns datapath load/store requests into a held
// request/acknowledge memory handshake, with alignment checking, timeout and error counting.
module dmem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic [7:0]  err_count,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_load;
    logic [1:0]     r_size;
    logic [1:0]     r_off;
    logic           r_sext;
    logic [31:0]    r_rdata;
    logic           r_bus_err;
    logic [7:0]     r_err_count;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;

    logic           w_req;
    logic           w_mis;
    logic           w_start;
    logic           w_mis_evt;
    logic           w_ack;
    logic           w_timeout;
    logic           w_stall;
    logic           w_misaligned;

    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic res;
        case (sz)
            2'b00:   res = 1'b0;
            2'b01:   res = a[0];
            default: res = (a != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] res;
        case (sz)
            2'b00:   res = 4'b0001 << a;
            2'b01:   res = a[1] ? 4'b1100 : 4'b0011;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] res;
        case (sz)
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Lane select by offset, then sign- or zero-extend to 32 bits.
    function automatic logic [31:0] f_format(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sext);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res = {{24{sext & b[7]}}, b};
            2'b01:   res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign w_req     = mem_read | mem_write;
    assign w_mis     = f_misaligned(size, addr[1:0]);
    assign w_start   = (r_state == S_IDLE) & w_req & ~w_mis;
    assign w_mis_evt = (r_state == S_IDLE) & w_req & w_mis;
    assign w_ack     = (r_state == S_WAIT) & m_ack;
    assign w_timeout = (r_state == S_WAIT) & ~m_ack & (r_cnt == TO_LAST);

    // Next-state and combinational handshake outputs.
    always_comb begin
        w_next       = r_state;
        w_stall      = 1'b0;
        w_misaligned = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && w_mis) begin
                    w_misaligned = 1'b1;
                end else if (w_req) begin
                    w_stall = 1'b1;
                    w_next  = S_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_stall = w_req;
                if (m_ack || w_timeout) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture of the memory-side request and the load-formatting context.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 32'h0000_0000;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0000_0000;
            r_load  <= 1'b0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_sext  <= 1'b0;
        end else if (w_start) begin
            r_addr  <= {addr[31:2], 2'b00};
            r_we    <= mem_write;
            r_be    <= f_be(size, addr[1:0]);
            r_wdata <= f_wdata(size, wdata);
            r_load  <= ~mem_write;
            r_size  <= size;
            r_off   <= addr[1:0];
            r_sext  <= sign_ext;
        end else begin
            r_addr  <= r_addr;
            r_we    <= r_we;
            r_be    <= r_be;
            r_wdata <= r_wdata;
            r_load  <= r_load;
            r_size  <= r_size;
            r_off   <= r_off;
            r_sext  <= r_sext;
        end
    end

    // WAIT-cycle counter: cleared on entry, advances while no ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !m_ack && !w_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Load data, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= 32'h0000_0000;
            r_bus_err   <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_bus_err <= w_timeout;
            if (w_mis_evt && !mem_write) begin
                r_rdata <= 32'h0000_0000;
            end else if (w_ack && r_load) begin
                r_rdata <= f_format(m_rdata, r_size, r_off, r_sext);
            end else if (w_timeout) begin
                r_rdata <= 32'h0000_0000;
            end else begin
                r_rdata <= r_rdata;
            end
            if ((w_mis_evt || w_timeout) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'h01;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

    assign m_req      = (r_state == S_WAIT);
    assign m_addr     = r_addr;
    assign m_we       = r_we;
    assign m_be       = r_be;
    assign m_wdata    = r_wdata;
    assign rdata      = r_rdata;
    assign bus_err    = r_bus_err;
    assign err_count  = r_err_count;
    assign stall      = w_stall;
    assign misaligned = w_misaligned;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT=4; expectations are hand-computed.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic [7:0]  err_count;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
        .err_count(err_count), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; m_ack = 1'b0; m_rdata = 32'h0;
        step(); step();
        rst = 1'b0; #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_m_req", m_req, 32'h0);
        chk("rst_stall", stall, 32'h0);
        chk("rst_err_count", err_count, 32'h0);
        chk("rst_m_be", m_be, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_bus_err", bus_err, 32'h0);

        // word store, ack in the second WAIT cycle
        mem_write = 1'b1; size = 2'b10; addr = 32'h104; wdata = 32'hCAFEBABE; #1;
        chk("sw_idle_stall", stall, 32'h1);
        chk("sw_idle_mis", misaligned, 32'h0);
        chk("sw_idle_req", m_req, 32'h0);
        step();
        chk("sw_w1_req", m_req, 32'h1);
        chk("sw_w1_addr", m_addr, 32'h104);
        chk("sw_w1_be", m_be, 32'hF);
        chk("sw_w1_we", m_we, 32'h1);
        chk("sw_w1_wdata", m_wdata, 32'hCAFEBABE);
        chk("sw_w1_stall", stall, 32'h1);
        step();
        chk("sw_w2_req", m_req, 32'h1);
        chk("sw_w2_stall", stall, 32'h1);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0; #1;
        chk("sw_done_stall", stall, 32'h0);
        chk("sw_done_req", m_req, 32'h0);
        chk("sw_done_rdata", rdata, 32'h0);
        mem_write = 1'b0;
        step();
        chk("sw_idle_req2", m_req, 32'h0);
        chk("sw_addr_held", m_addr, 32'h104);

        // byte load at lane 3, signed then unsigned
        mem_read = 1'b1; size = 2'b00; addr = 32'h203; sign_ext = 1'b1; #1;
        chk("lb_idle_stall", stall, 32'h1);
        step();
        chk("lb_be", m_be, 32'h8);
        chk("lb_we", m_we, 32'h0);
        chk("lb_addr", m_addr, 32'h200);
        m_rdata = 32'h80FF_0000; m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("lb_sext_rdata", rdata, 32'hFFFFFF80);
        chk("lb_done_stall", stall, 32'h0);
        sign_ext = 1'b0;
        step();
        chk("lbu_idle_stall", stall, 32'h1);
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("lbu_rdata", rdata, 32'h00000080);
        mem_read = 1'b0;
        step();

        // half store at upper half, then misaligned half load
        mem_write = 1'b1; size = 2'b01; addr = 32'h302; wdata = 32'h1234ABCD; #1;
        chk("sh_idle_stall", stall, 32'h1);
        step();
        chk("sh_wdata", m_wdata, 32'hABCDABCD);
        chk("sh_be", m_be, 32'hC);
        chk("sh_addr", m_addr, 32'h300);
        m_ack = 1'b1;
        step();
        m_ack = 1'b0; mem_write = 1'b0;
        chk("sh_rdata_kept", rdata, 32'h00000080);
        step();
        mem_read = 1'b1; size = 2'b01; addr = 32'h301; #1;
        chk("lh_mis_pulse", misaligned, 32'h1);
        chk("lh_mis_stall", stall, 32'h0);
        chk("lh_mis_req", m_req, 32'h0);
        step();
        mem_read = 1'b0; #1;
        chk("lh_mis_errcnt", err_count, 32'h1);
        chk("lh_mis_rdata", rdata, 32'h0);
        chk("lh_mis_req2", m_req, 32'h0);
        chk("lh_mis_clear", misaligned, 32'h0);

        // word load pass-through, then same request times out
        mem_read = 1'b1; size = 2'b10; addr = 32'h400; #1;
        step();
        m_rdata = 32'h11223344; m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        chk("lw_rdata", rdata, 32'h11223344);
        step();
        chk("to_idle_stall", stall, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_wait_req", m_req, 32'h1);
            chk("to_wait_buserr", bus_err, 32'h0);
        end
        step();
        chk("to_done_buserr", bus_err, 32'h1);
        chk("to_done_req", m_req, 32'h0);
        chk("to_done_rdata", rdata, 32'h0);
        chk("to_done_errcnt", err_count, 32'h2);
        chk("to_done_stall", stall, 32'h0);
        mem_read = 1'b0;
        step();
        chk("to_idle_buserr", bus_err, 32'h0);
        chk("to_idle_req", m_req, 32'h0);

        // reset during WAIT, late ack must be ignored
        mem_read = 1'b1; size = 2'b10; addr = 32'h500; #1;
        step();
        chk("rw_w1_req", m_req, 32'h1);
        rst = 1'b1;
        step();
        chk("rw_req", m_req, 32'h0);
        chk("rw_errcnt", err_count, 32'h0);
        chk("rw_rdata", rdata, 32'h0);
        chk("rw_addr", m_addr, 32'h0);
        rst = 1'b0; mem_read = 1'b0;
        step();
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        m_ack = 1'b0;
        chk("rw_ack_req", m_req, 32'h0);
        chk("rw_ack_rdata", rdata, 32'h0);
        chk("rw_ack_buserr", bus_err, 32'h0);
        chk("rw_ack_stall", stall, 32'h0);
        mem_read = 1'b1; #1;
        chk("rw_idle_stall", stall, 32'h1);
        mem_read = 1'b0; #1;
        step();
        chk("rw_nostart_req", m_req, 32'h0);

        // read and write together: store wins
        mem_read = 1'b1; mem_write = 1'b1; size = 2'b00; addr = 32'h601; wdata = 32'h000000A5; #1;
        step();
        chk("rw_both_we", m_we, 32'h1);
        chk("rw_both_be", m_be, 32'h2);
        chk("rw_both_wdata", m_wdata, 32'hA5A5A5A5);
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        step();
        m_ack = 1'b0;
        chk("rw_both_rdata", rdata, 32'h0);
        mem_read = 1'b0; mem_write = 1'b0;
        step();

        // 300 misaligned events saturate the error counter
        mem_read = 1'b1; size = 2'b10; addr = 32'h701; #1;
        chk("sat_mis", misaligned, 32'h1);
        chk("sat_stall", stall, 32'h0);
        for (int i = 0; i < 254; i++) step();
        chk("sat_254", err_count, 32'd254);
        step();
        chk("sat_255", err_count, 32'd255);
        for (int i = 0; i < 45; i++) step();
        chk("sat_300", err_count, 32'd255);
        chk("sat_req", m_req, 32'h0);
        mem_read = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
